// File: rtl/tlul_pkg.sv
// TL-UL type and constant package shared by the host bridge and its tracker.
//   tl_h2d_t : host-to-device A-channel fields plus d_ready
//   tl_d2h_t : device-to-host D-channel fields plus a_ready
//   Opcode enums for both channels, bus width constants.
package tlul_pkg;

    localparam int TL_AW  = 32;  // address width
    localparam int TL_DW  = 32;  // data width
    localparam int TL_DBW = 4;   // mask width (bytes per beat)
    localparam int TL_AIW = 8;   // a_source / d_source width
    localparam int TL_SZW = 2;   // size field width
    localparam int TL_UW  = 8;   // user field width

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_UW-1:0]  a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_UW-1:0]  d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_tracker.sv
// In-flight transaction tracker: synchronous FIFO of {source, we} entries.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   push_i, push_src_i/we_i  enqueue an entry
//   pop_i                    dequeue the head (ignored when empty)
//   head_src_o, head_we_o    current head entry
//   full_o, empty_o, count_o occupancy status
// A push while full is accepted when a pop happens in the same cycle.
module tlul_host_tracker #(
    parameter int Depth   = 2,
    parameter int SourceW = 3,
    parameter int CntW    = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [SourceW-1:0] push_src_i,
    input  logic               push_we_i,
    input  logic               pop_i,
    output logic [SourceW-1:0] head_src_o,
    output logic               head_we_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CntW-1:0]    count_o
);

    localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [SourceW:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Depth is a power of two but may be 1, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign count_o = cnt_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign {head_src_o, head_we_o} = mem_q[rptr_q];

    always_comb begin
        wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= {push_src_i, push_we_i};
        end
    end

endmodule

// File: rtl/tlul_host_bridge.sv
// Initiator-side TL-UL bridge: req/gnt/rvalid memory port to TL-UL host port.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i, gnt_o                  request handshake (grant is combinational)
//   we_i, addr_i, wdata_i, be_i   request fields, held stable until gnt_o
//   rvalid_o, rdata_o, err_o      registered response, one-cycle pulse
//   tl_o                          A channel plus d_ready
//   tl_i                          D channel plus a_ready
// Every response is checked against the tracker head (source and opcode);
// responses with nothing outstanding are reported as errors.
module tlul_host_bridge
    import tlul_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int SourceW        = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic               init_q;
    logic [SourceW-1:0] src_q, src_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               a_valid, full, d_beat, mismatch;
    logic [SourceW-1:0] trk_head_src;
    logic               trk_head_we, trk_full, trk_empty;
    logic [CntW-1:0]    trk_cnt;

    tlul_host_tracker #(
        .Depth   (MaxOutstanding),
        .SourceW (SourceW)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (gnt_o),
        .push_src_i (src_q),
        .push_we_i  (we_i),
        .pop_i      (d_beat),
        .head_src_o (trk_head_src),
        .head_we_o  (trk_head_we),
        .full_o     (trk_full),
        .empty_o    (trk_empty),
        .count_o    (trk_cnt)
    );

    assign full    = (trk_cnt == CntW'(MaxOutstanding));
    assign a_valid = req_i & init_q & ~full;
    assign gnt_o   = a_valid & tl_i.a_ready;
    assign d_beat  = tl_i.d_valid & init_q;

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_size    = TL_SZW'(2);
        tl_o.a_source  = TL_AIW'(src_q);
        tl_o.a_address = {addr_i[31:2], 2'b00};
        tl_o.d_ready   = init_q;
        if (!we_i) begin
            tl_o.a_opcode = Get;
            tl_o.a_mask   = 4'hF;
        end else begin
            tl_o.a_opcode = (be_i == 4'hF) ? PutFullData : PutPartialData;
            tl_o.a_mask   = be_i;
            tl_o.a_data   = wdata_i;
        end
    end

    // Source IDs cycle over 0..MaxOutstanding-1 in grant order.
    always_comb begin
        src_d = src_q;
        if (gnt_o) begin
            src_d = (src_q == SourceW'(MaxOutstanding - 1)) ? '0 : src_q + SourceW'(1);
        end
    end

    always_comb begin
        mismatch = (tl_i.d_source != TL_AIW'(trk_head_src)) |
                   (trk_head_we ? (tl_i.d_opcode != AccessAck)
                                : (tl_i.d_opcode != AccessAckData));
        rvalid_d = d_beat;
        err_d    = d_beat & (trk_empty | tl_i.d_error | mismatch);
        rdata_d  = '0;
        if (d_beat && !err_d && !trk_head_we) begin
            rdata_d = tl_i.d_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q   <= 1'b0;
            src_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            src_q    <= src_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Fields the bridge deliberately ignores.
    logic unused_sigs;
    assign unused_sigs = ^{addr_i[1:0], trk_full, tl_i.d_param, tl_i.d_size,
                           tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_bridge.sv
module tb_tlul_host_bridge;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    tlul_host_bridge #(.MaxOutstanding(2), .SourceW(3)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .tl_o     (tl_o),
        .tl_i     (tl_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          tag;
    } exp_t;
    exp_t exp_q[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Response monitor: every rvalid_o pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid with rdata %h err %b, expected none (cycle %0d)",
                         rdata_o, err_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("resp%0d_rdata", e.tag), rdata_o, e.rdata);
                chk($sformatf("resp%0d_err", e.tag), 32'(err_o), 32'(e.err));
                chk($sformatf("resp%0d_cycle", e.tag), 32'(cyc), 32'(e.due));
            end
        end
    end

    int tag = 0;

    // Starts and ends just after a rising edge. Waits for the grant and
    // checks the A-channel fields in the granting cycle.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [2:0] eop, input logic [31:0] eaddr,
                          input logic [3:0] emask, input logic [31:0] edata, input int esrc);
        bit got = 0;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt_o === 1'b1) begin
                got = 1;
                chk("a_valid", 32'(tl_o.a_valid), 32'd1);
                chk("a_opcode", 32'(tl_o.a_opcode), 32'(eop));
                chk("a_address", tl_o.a_address, eaddr);
                chk("a_mask", 32'(tl_o.a_mask), 32'(emask));
                chk("a_data", tl_o.a_data, edata);
                chk("a_source", 32'(tl_o.a_source), 32'(esrc));
                chk("a_size", 32'(tl_o.a_size), 32'd2);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL grant_timeout: got no gnt_o for addr %h, expected grant", addr);
        end
        req_i = 1'b0;
    endtask

    // Drives one D beat for one cycle and records the expected response.
    task automatic d_beat(input int src, input tl_d_op_e op, input logic [31:0] data,
                          input logic derr, input logic [31:0] erd, input logic eerr);
        tl_i.d_valid  = 1'b1;
        tl_i.d_source = 8'(src);
        tl_i.d_opcode = op;
        tl_i.d_data   = data;
        tl_i.d_error  = derr;
        exp_q.push_back('{erd, eerr, cyc + 1, tag});
        tag++;
        @(posedge clk); #1;
        tl_i.d_valid = 1'b0;
        tl_i.d_data  = '0;
        tl_i.d_error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_i = '0;
        tl_i.a_ready = 1'b1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Request already pending while reset is applied.
        req_i = 1'b1; addr_i = 32'h0000_0104;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("rst_d_ready", 32'(tl_o.d_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("init_gnt", 32'(gnt_o), 32'd0);
        @(posedge clk); #1;

        // Word read
        do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'd4, 32'h0000_0104, 4'hF, 32'h0, 0);
        chk("d_ready", 32'(tl_o.d_ready), 32'd1);
        d_beat(0, AccessAckData, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Partial write
        do_req(1'b1, 32'h0000_0202, 32'h5566_7788, 4'b0011, 3'd1, 32'h0000_0200, 4'h3,
               32'h5566_7788, 1);
        d_beat(1, AccessAck, 32'hFFFF_0000, 1'b0, 32'h0, 1'b0);

        // Outstanding limit: two reads fill the tracker, third waits
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'd4, 32'h0000_0010, 4'hF, 32'h0, 0);
        do_req(1'b0, 32'h0000_0014, 32'h0, 4'hF, 3'd4, 32'h0000_0014, 4'hF, 32'h0, 1);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0018;
        repeat (3) begin
            @(negedge clk);
            chk("full_gnt", 32'(gnt_o), 32'd0);
            chk("full_a_valid", 32'(tl_o.a_valid), 32'd0);
            @(posedge clk); #1;
        end
        tl_i.d_valid = 1'b1; tl_i.d_source = 8'd0; tl_i.d_opcode = AccessAckData;
        tl_i.d_data = 32'hA0A0_0001;
        exp_q.push_back('{32'hA0A0_0001, 1'b0, cyc + 1, tag});
        tag++;
        @(negedge clk);
        chk("free_same_cycle_gnt", 32'(gnt_o), 32'd0);
        @(posedge clk); #1;
        tl_i.d_valid = 1'b0; tl_i.d_data = '0;
        @(negedge clk);
        chk("free_next_gnt", 32'(gnt_o), 32'd1);
        chk("wrap_a_source", 32'(tl_o.a_source), 32'd0);
        chk("wrap_a_address", tl_o.a_address, 32'h0000_0018);
        @(posedge clk); #1;
        req_i = 1'b0;
        // Back-to-back responses
        d_beat(1, AccessAckData, 32'hA0A0_0002, 1'b0, 32'hA0A0_0002, 1'b0);
        d_beat(0, AccessAckData, 32'hA0A0_0003, 1'b0, 32'hA0A0_0003, 1'b0);

        // Source mismatch
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'd4, 32'h0000_0020, 4'hF, 32'h0, 1);
        d_beat(0, AccessAckData, 32'h0000_1234, 1'b0, 32'h0, 1'b1);
        // Opcode mismatch: read answered with AccessAck
        do_req(1'b0, 32'h0000_0024, 32'h0, 4'hF, 3'd4, 32'h0000_0024, 4'hF, 32'h0, 0);
        d_beat(0, AccessAck, 32'h0000_5678, 1'b0, 32'h0, 1'b1);
        // Full write with device error
        do_req(1'b1, 32'h0000_0043, 32'hCAFE_F00D, 4'hF, 3'd0, 32'h0000_0040, 4'hF,
               32'hCAFE_F00D, 1);
        d_beat(1, AccessAck, 32'h0, 1'b1, 32'h0, 1'b1);
        // Read with device error
        do_req(1'b0, 32'h0000_0044, 32'h0, 4'hF, 3'd4, 32'h0000_0044, 4'hF, 32'h0, 0);
        d_beat(0, AccessAckData, 32'h0000_0099, 1'b1, 32'h0, 1'b1);

        // Spurious beat with empty tracker
        d_beat(3, AccessAckData, 32'h0000_0077, 1'b0, 32'h0, 1'b1);

        // Two reads still fit, so the spurious beat left count at 0
        do_req(1'b0, 32'h0000_0300, 32'h0, 4'hF, 3'd4, 32'h0000_0300, 4'hF, 32'h0, 1);
        do_req(1'b0, 32'h0000_0304, 32'h0, 4'hF, 3'd4, 32'h0000_0304, 4'hF, 32'h0, 0);
        req_i = 1'b1; addr_i = 32'h0000_030C;
        @(negedge clk);
        chk("full2_gnt", 32'(gnt_o), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_rdata", rdata_o, 32'd0);
        chk("midrst_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("midrst_d_ready", 32'(tl_o.d_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("rel_d_ready", 32'(tl_o.d_ready), 32'd0);
        @(posedge clk); #1;
        req_i = 1'b0;
        // A stale response for a pre-reset transaction is spurious now
        d_beat(1, AccessAckData, 32'h0000_0BAD, 1'b0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_0400, 32'h0, 4'hF, 3'd4, 32'h0000_0400, 4'hF, 32'h0, 0);
        d_beat(0, AccessAckData, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
